sram_2rw_masked: RTL

//  Parametrised two-port read/write SRAM behavioural model: successor to the fixed 32x32 BTB array.

---
 rtl/sram_2rw_masked.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sram_2rw_masked.sv
// Two-port read/write SRAM model with per-lane write masks and a post-reset clearing sweep.
// Optional feature: define SRAM_BYPASS_EN so that a read colliding with the other port's write returns the merged new word.
module sram_2rw_masked #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int WMASK_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   csb0,
    input  logic                   web0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    output logic [DATA_WIDTH-1:0]  dout0,
    input  logic                   csb1,
    input  logic                   web1,
    input  logic [WMASK_WIDTH-1:0] wmask1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0]  din1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   init_done
);

    localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic                    init_done_r;
    logic [DATA_WIDTH-1:0]   dout0_r;
    logic [DATA_WIDTH-1:0]   dout1_r;
    logic [DATA_WIDTH-1:0]   mem_r [RAM_DEPTH];

    logic                    ready_s;
    logic                    wr0_s;
    logic                    wr1_s;
    logic                    rd0_s;
    logic                    rd1_s;
    logic                    same_addr_s;
    logic [DATA_WIDTH-1:0]   rd0_word_s;
    logic [DATA_WIDTH-1:0]   rd1_word_s;

    // Replace the lanes of old_word selected by mask with the matching lanes of new_word.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0]  old_word,
        input logic [DATA_WIDTH-1:0]  new_word,
        input logic [WMASK_WIDTH-1:0] mask
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < WMASK_WIDTH; i++) begin
            if (mask[i]) begin
                res[i*LANE_WIDTH +: LANE_WIDTH] = new_word[i*LANE_WIDTH +: LANE_WIDTH];
            end else begin
                res[i*LANE_WIDTH +: LANE_WIDTH] = old_word[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
        return res;
    endfunction

    assign ready_s     = (state_r == ST_READY);
    assign wr0_s       = ready_s && !csb0 && !web0;
    assign wr1_s       = ready_s && !csb1 && !web1;
    assign rd0_s       = ready_s && !csb0 && web0;
    assign rd1_s       = ready_s && !csb1 && web1;
    assign same_addr_s = (addr0 == addr1);

    // Read data selection: stored word, optionally forwarded from the other port's colliding write.
    always_comb begin
        rd0_word_s = mem_r[addr0];
        rd1_word_s = mem_r[addr1];
`ifdef SRAM_BYPASS_EN
        if (wr1_s && same_addr_s) begin
            rd0_word_s = merge_lanes(mem_r[addr0], din1, wmask1);
        end else begin
            rd0_word_s = mem_r[addr0];
        end
        if (wr0_s && same_addr_s) begin
            rd1_word_s = merge_lanes(mem_r[addr1], din0, wmask0);
        end else begin
            rd1_word_s = mem_r[addr1];
        end
`else
        rd0_word_s = mem_r[addr0];
        rd1_word_s = mem_r[addr1];
`endif
    end

    // Sequencer: clearing sweep after reset, then READY until the next reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    ptr_r <= ptr_r + PTR_ONE;
                    if (ptr_r == PTR_LAST) begin
                        state_r     <= ST_READY;
                        init_done_r <= 1'b1;
                    end else begin
                        state_r     <= ST_INIT;
                        init_done_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    state_r     <= ST_READY;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    ptr_r       <= {ADDR_WIDTH{1'b0}};
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: sweep writes during INIT, masked port writes once READY (port 0 wins shared lanes).
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[ptr_r] <= INIT_VALUE;
        end else if (wr0_s && wr1_s && same_addr_s) begin
            mem_r[addr0] <= merge_lanes(merge_lanes(mem_r[addr0], din1, wmask1), din0, wmask0);
        end else begin
            if (wr0_s) begin
                mem_r[addr0] <= merge_lanes(mem_r[addr0], din0, wmask0);
            end
            if (wr1_s) begin
                mem_r[addr1] <= merge_lanes(mem_r[addr1], din1, wmask1);
            end
        end
    end

    // Read data registers: update only on a read, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout0_r <= {DATA_WIDTH{1'b0}};
            dout1_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (rd0_s) begin
                dout0_r <= rd0_word_s;
            end
            if (rd1_s) begin
                dout1_r <= rd1_word_s;
            end
        end
    end

    assign dout0     = dout0_r;
    assign dout1     = dout1_r;
    assign init_done = init_done_r;

endmodule
